// File: rtl/render_pkg.sv
// Shared render pipeline parameters and the scan generator state encoding.
// The coordinate widths are common to every stage through the output stage.
package render_pkg;

  localparam int X_W    = 11;
  localparam int Y_W    = 12;
  localparam int PROG_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/shape_scan_gen_if.sv
// Pixel beat stream leaving the shape scan generator: coordinate, latched
// command fields and a valid/ready handshake.
interface shape_scan_gen_if
  import render_pkg::*;
();

  logic              out_valid;
  logic              out_ready;
  logic [X_W-1:0]    x_out;
  logic [Y_W-1:0]    y_out;
  logic [PROG_W-1:0] program_out;
  logic [X_W-1:0]    shape_width_out;
  logic [Y_W-1:0]    shape_height_out;
  logic              last_out;

  modport master (
    output out_valid,
    input  out_ready,
    output x_out,
    output y_out,
    output program_out,
    output shape_width_out,
    output shape_height_out,
    output last_out
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  x_out,
    input  y_out,
    input  program_out,
    input  shape_width_out,
    input  shape_height_out,
    input  last_out
  );

endinterface

// File: rtl/shape_scan_gen.sv
// Shape scan generator: turns one shape command into a row-major stream of
// pixel coordinates over the bounding box, with downstream backpressure.
module shape_scan_gen
  import render_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PROG_W-1:0] program_in,
  input  logic [X_W-1:0]    shape_width,
  input  logic [Y_W-1:0]    shape_height,
  output logic              busy,
  output logic              done,
  shape_scan_gen_if.master  pix
);

  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  scan_state_e       state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [PROG_W-1:0] prog_q, prog_d;
  logic [X_W-1:0]    w_q, w_d;
  logic [Y_W-1:0]    h_q, h_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic xAtEnd;
  logic yAtEnd;
  logic xfer;

  assign xAtEnd = (x_q == (w_q - X_ONE));
  assign yAtEnd = (y_q == (h_q - Y_ONE));
  assign xfer   = valid_q && pix.out_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    prog_d  = prog_q;
    w_d     = w_q;
    h_d     = h_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          prog_d = program_in;
          w_d    = shape_width;
          h_d    = shape_height;
          x_d    = '0;
          y_d    = '0;
          busy_d = 1'b1;
          if ((shape_width == '0) || (shape_height == '0)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SCAN;
            valid_d = 1'b1;
            last_d  = (shape_width == X_ONE) && (shape_height == Y_ONE);
          end
        end
      end

      SCAN: begin
        // last_out is precomputed for the coordinate being advanced to, so it
        // is registered alongside x/y and holds with them during a stall.
        if (xfer) begin
          if (!xAtEnd) begin
            x_d    = x_q + X_ONE;
            last_d = ((x_q + X_ONE) == (w_q - X_ONE)) && yAtEnd;
          end else if (!yAtEnd) begin
            x_d    = '0;
            y_d    = y_q + Y_ONE;
            last_d = (w_q == X_ONE) && ((y_q + Y_ONE) == (h_q - Y_ONE));
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      prog_q  <= '0;
      w_q     <= '0;
      h_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      prog_q  <= prog_d;
      w_q     <= w_d;
      h_q     <= h_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign pix.out_valid        = valid_q;
  assign pix.x_out            = x_q;
  assign pix.y_out            = y_q;
  assign pix.program_out      = prog_q;
  assign pix.shape_width_out  = w_q;
  assign pix.shape_height_out = h_q;
  assign pix.last_out         = last_q;

endmodule
